// File: rtl/shift_add_mult_seq.sv
// Sequential shift-add multiplier: control FSM and A/B/X datapath in one block.
// Product Din*B is formed one multiplier bit per ADD/SHIFT pair into {A,B}, X is the extension bit.
module shift_add_mult_seq #(
    parameter int unsigned WIDTH  = 8,
    parameter bit          SIGNED = 1'b1
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Run,
    input  logic             ClearA_LoadB,
    input  logic [WIDTH-1:0] Din,
    output logic [WIDTH-1:0] Aval,
    output logic [WIDTH-1:0] Bval,
    output logic             X,
    output logic             Busy,
    output logic             Done
);

    localparam int unsigned CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ADD   = 2'd1,
        SHIFT = 2'd2,
        HOLD  = 2'd3
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] s_q;
    logic             x_q;
    logic [CNT_W-1:0] cnt_q;
    logic             run_q;
    logic             start_c;
    logic             last_c;
    logic [WIDTH:0]   a_ext_c;
    logic [WIDTH:0]   s_ext_c;
    logic [WIDTH:0]   sum_c;

    assign start_c = Run & ~run_q;
    assign last_c  = (cnt_q == LAST_ITER);

    // Outputs are the register contents themselves
    assign Aval = a_q;
    assign Bval = b_q;
    assign X    = x_q;

    // (WIDTH+1)-bit partial-product update; signed mode subtracts on the last iteration
    always_comb begin
        a_ext_c = {1'b0, a_q};
        s_ext_c = {1'b0, s_q};
        sum_c   = '0;
        if (SIGNED) begin
            a_ext_c = {a_q[WIDTH-1], a_q};
            s_ext_c = {s_q[WIDTH-1], s_q};
        end
        if (SIGNED && last_c) begin
            sum_c = a_ext_c - s_ext_c;
        end else begin
            sum_c = a_ext_c + s_ext_c;
        end
    end

    // State register
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start_c) state_next = ADD;
            ADD:     state_next = SHIFT;
            SHIFT:   state_next = last_c ? HOLD : ADD;
            HOLD:    if (!Run) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Handshake outputs: Busy tracks ADD/SHIFT, Done follows HOLD one cycle later
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            run_q <= 1'b0;
            Busy  <= 1'b0;
            Done  <= 1'b0;
        end else begin
            run_q <= Run;
            Busy  <= (state_next == ADD) || (state_next == SHIFT);
            Done  <= (state == HOLD);
        end
    end

    // Datapath: load/clear in IDLE, accumulate in ADD, arithmetic right shift of {X,A,B} in SHIFT
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            a_q   <= '0;
            b_q   <= '0;
            s_q   <= '0;
            x_q   <= 1'b0;
            cnt_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_c) begin
                        s_q   <= Din;
                        a_q   <= '0;
                        x_q   <= 1'b0;
                        cnt_q <= '0;
                    end else if (ClearA_LoadB) begin
                        a_q <= '0;
                        x_q <= 1'b0;
                        b_q <= Din;
                    end
                end
                ADD: begin
                    if (b_q[0]) begin
                        {x_q, a_q} <= sum_c;
                    end
                end
                SHIFT: begin
                    b_q <= {a_q[0], b_q[WIDTH-1:1]};
                    a_q <= {x_q, a_q[WIDTH-1:1]};
                    if (!SIGNED) begin
                        x_q <= 1'b0;
                    end
                    if (!last_c) begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_shift_add_mult_seq.sv
// Bench for shift_add_mult_seq: 8-bit signed and 4-bit unsigned instances against an arithmetic model.
module tb_shift_add_mult_seq;

    logic Clk = 1'b0;
    logic Reset;
    always #5 Clk = ~Clk;

    logic       run8, cl8, x8, busy8, done8;
    logic [7:0] din8, a8, b8;
    logic       run4, cl4, x4, busy4, done4;
    logic [3:0] din4, a4, b4;

    int vectors     = 0;
    int miscompares = 0;

    shift_add_mult_seq #(.WIDTH(8), .SIGNED(1'b1)) dut8 (
        .Clk(Clk), .Reset(Reset), .Run(run8), .ClearA_LoadB(cl8), .Din(din8),
        .Aval(a8), .Bval(b8), .X(x8), .Busy(busy8), .Done(done8)
    );

    shift_add_mult_seq #(.WIDTH(4), .SIGNED(1'b0)) dut4 (
        .Clk(Clk), .Reset(Reset), .Run(run4), .ClearA_LoadB(cl4), .Din(din4),
        .Aval(a4), .Bval(b4), .X(x4), .Busy(busy4), .Done(done4)
    );

    typedef struct {
        logic [7:0] b;
        logic [7:0] din;
        bit         chain;
        logic [7:0] ea;
        logic [7:0] eb;
        logic       ex;
    } vec_t;

    vec_t tbl[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge Clk);
        #1;
    endtask

    // Reference: signed product as plain integers; X is the sign of the 16-bit result
    function automatic logic [16:0] ref8(input logic [7:0] b, input logic [7:0] s);
        int          p;
        logic [15:0] r;
        p = int'($signed(b)) * int'($signed(s));
        r = 16'(p);
        return {r[15], r};
    endfunction

    // Reference: unsigned 4x4 product, X is zero at the end
    function automatic logic [8:0] ref4(input logic [3:0] b, input logic [3:0] s);
        int p;
        p = int'(b) * int'(s);
        return {1'b0, 8'(p)};
    endfunction

    task automatic load8(input logic [7:0] b);
        cl8  = 1'b1;
        din8 = b;
        tick();
        cl8  = 1'b0;
    endtask

    task automatic load4(input logic [3:0] b);
        cl4  = 1'b1;
        din4 = b;
        tick();
        cl4  = 1'b0;
    endtask

    // Run pulse, then count edges until Done (0 if the budget expires)
    task automatic mult8(input logic [7:0] d, output int lat);
        din8 = d;
        run8 = 1'b1;
        tick();
        run8 = 1'b0;
        lat  = 0;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (done8) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic mult4(input logic [3:0] d, output int lat);
        din4 = d;
        run4 = 1'b1;
        tick();
        run4 = 1'b0;
        lat  = 0;
        for (int i = 1; i <= 30; i++) begin
            tick();
            if (done4) begin
                lat = i;
                break;
            end
        end
    endtask

    initial begin
        int          lat;
        logic [7:0]  bm;
        logic [7:0]  b_r;
        logic [7:0]  d_r;
        logic [16:0] e8;
        logic [3:0]  bm4;
        logic [3:0]  b4_r;
        logic [3:0]  d4_r;
        logic [8:0]  e4;
        bit          busy_seen;

        tbl[0] = '{b: 8'h07, din: 8'h3B, chain: 1'b0, ea: 8'h01, eb: 8'h9D, ex: 1'b0};
        tbl[1] = '{b: 8'h00, din: 8'h02, chain: 1'b1, ea: 8'hFF, eb: 8'h3A, ex: 1'b1};
        tbl[2] = '{b: 8'hF9, din: 8'h3B, chain: 1'b0, ea: 8'hFE, eb: 8'h63, ex: 1'b1};
        tbl[3] = '{b: 8'hFF, din: 8'hFF, chain: 1'b0, ea: 8'h00, eb: 8'h01, ex: 1'b0};
        tbl[4] = '{b: 8'h80, din: 8'h80, chain: 1'b0, ea: 8'h40, eb: 8'h00, ex: 1'b0};
        tbl[5] = '{b: 8'h00, din: 8'h7F, chain: 1'b0, ea: 8'h00, eb: 8'h00, ex: 1'b0};
        tbl[6] = '{b: 8'h7F, din: 8'h80, chain: 1'b0, ea: 8'hC0, eb: 8'h80, ex: 1'b1};

        Reset = 1'b1;
        run8 = 1'b0; cl8 = 1'b0; din8 = '0;
        run4 = 1'b0; cl4 = 1'b0; din4 = '0;
        tick();
        tick();
        Reset = 1'b0;
        tick();

        check("reset_a8", a8, 8'h00);
        check("reset_b8", b8, 8'h00);
        check("reset_x8", x8, 1'b0);
        check("reset_busy8", busy8, 1'b0);
        check("reset_done8", done8, 1'b0);
        check("reset_a4", a4, 4'h0);
        check("reset_busy4", busy4, 1'b0);

        // Directed table, 8-bit signed
        for (int i = 0; i < 7; i++) begin
            if (!tbl[i].chain) begin
                load8(tbl[i].b);
                check($sformatf("v%0d_load_b", i), b8, tbl[i].b);
                check($sformatf("v%0d_load_a", i), a8, 8'h00);
            end
            mult8(tbl[i].din, lat);
            check($sformatf("v%0d_latency", i), lat, 17);
            check($sformatf("v%0d_a", i), a8, tbl[i].ea);
            check($sformatf("v%0d_b", i), b8, tbl[i].eb);
            check($sformatf("v%0d_x", i), x8, tbl[i].ex);
            check($sformatf("v%0d_busy", i), busy8, 1'b0);
            tick();
            check($sformatf("v%0d_done_drop", i), done8, 1'b0);
        end

        // Random 8-bit signed, with occasional chaining of the low product
        bm = b8;
        for (int i = 0; i < 20; i++) begin
            b_r = 8'($urandom);
            d_r = 8'($urandom);
            if ($urandom_range(3) != 0) begin
                load8(b_r);
                bm = b_r;
            end
            e8 = ref8(bm, d_r);
            mult8(d_r, lat);
            check($sformatf("r8_%0d_latency", i), lat, 17);
            check($sformatf("r8_%0d_prod", i), {x8, a8, b8}, e8);
            bm = e8[7:0];
            tick();
        end

        // 4-bit unsigned hand sequence
        load4(4'hF);
        mult4(4'hF, lat);
        check("u4_ff_latency", lat, 9);
        check("u4_ff_a", a4, 4'hE);
        check("u4_ff_b", b4, 4'h1);
        check("u4_ff_x", x4, 1'b0);
        tick();
        load4(4'hA);
        mult4(4'h0, lat);
        check("u4_a0_a", a4, 4'h0);
        check("u4_a0_b", b4, 4'h0);
        tick();

        // Random 4-bit unsigned
        bm4 = b4;
        for (int i = 0; i < 12; i++) begin
            b4_r = 4'($urandom);
            d4_r = 4'($urandom);
            if ($urandom_range(2) != 0) begin
                load4(b4_r);
                bm4 = b4_r;
            end
            e4 = ref4(bm4, d4_r);
            mult4(d4_r, lat);
            check($sformatf("r4_%0d_latency", i), lat, 9);
            check($sformatf("r4_%0d_prod", i), {x4, a4, b4}, e4);
            bm4 = e4[3:0];
            tick();
        end

        // Reset in the middle of a multiply
        load8(8'h07);
        din8 = 8'h3B;
        run8 = 1'b1;
        tick();
        run8 = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        check("mid_busy_before_reset", busy8, 1'b1);
        #2;
        Reset = 1'b1;
        #1;
        check("mid_reset_a", a8, 8'h00);
        check("mid_reset_b", b8, 8'h00);
        check("mid_reset_x", x8, 1'b0);
        check("mid_reset_busy", busy8, 1'b0);
        check("mid_reset_done", done8, 1'b0);
        tick();
        tick();
        Reset = 1'b0;
        for (int i = 0; i < 20; i++) tick();
        check("post_reset_busy", busy8, 1'b0);
        check("post_reset_done", done8, 1'b0);
        check("post_reset_ab", {a8, b8}, 16'h0000);

        // Disturb inputs while busy; Run held high through HOLD
        load8(8'h07);
        din8 = 8'h3B;
        run8 = 1'b1;
        tick();
        run8 = 1'b0;
        tick();
        tick();
        run8 = 1'b1;
        tick();
        run8 = 1'b0;
        tick();
        cl8  = 1'b1;
        din8 = 8'hAA;
        run8 = 1'b1;
        lat  = 0;
        busy_seen = 1'b0;
        for (int i = 5; i <= 40; i++) begin
            tick();
            if (busy8) busy_seen = 1'b1;
            if (done8) begin
                lat = i;
                break;
            end
        end
        cl8 = 1'b0;
        check("dist_busy_seen", busy_seen, 1'b1);
        check("dist_latency", lat, 17);
        check("dist_a", a8, 8'h01);
        check("dist_b", b8, 8'h9D);
        check("dist_x", x8, 1'b0);
        for (int i = 0; i < 5; i++) tick();
        check("hold_done_kept", done8, 1'b1);
        check("hold_no_restart", busy8, 1'b0);
        check("hold_frozen", {a8, b8}, 16'h019D);
        run8 = 1'b0;
        tick();
        tick();
        check("hold_release_done", done8, 1'b0);
        check("hold_release_busy", busy8, 1'b0);
        check("hold_release_b", b8, 8'h9D);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
